// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator: slot table for matrices keyed by (m,n,id).
// A request is accepted in IDLE and then either answered at once (bad
// parameters) or after a linear scan of every slot. During the scan the
// block collects the number of stored matrices for the pair, the lowest
// free slot and the slot holding each id. The RESP cycle uses those
// results to answer and to update the table.
module matrix_slot_allocator #(
    parameter int NUM_SLOTS   = 10,
    parameter int SLOT_WORDS  = 25,
    parameter int MAX_PER_DIM = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_op,
    input  logic [2:0] req_m,
    input  logic [2:0] req_n,
    input  logic [1:0] req_id,
    input  logic       clear,
    output logic       req_ready,
    output logic       resp_valid,
    output logic [7:0] resp_base,
    output logic [1:0] resp_id,
    output logic [1:0] resp_err,
    output logic [3:0] occupancy
);

    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(NUM_SLOTS + 1);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_PARAM = 2'd1;
    localparam logic [1:0] ERR_FULL  = 2'd2;
    localparam logic [1:0] ERR_NONE  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;
    state_t r_state, w_state_nxt;

    // latched request
    logic       r_op;
    logic [2:0] r_m, r_n;
    logic [1:0] r_id;
    logic       r_bad;

    // slot table
    logic [NUM_SLOTS-1:0] r_valid;
    logic [2:0]           r_sm  [NUM_SLOTS];
    logic [2:0]           r_sn  [NUM_SLOTS];
    logic [1:0]           r_sid [NUM_SLOTS];

    // scan results
    logic [IW-1:0]        r_idx;
    logic [CW-1:0]        r_cnt;
    logic                 r_free_found;
    logic [IW-1:0]        r_free_idx;
    logic [MAX_PER_DIM:1] r_hit_found;
    logic [IW-1:0]        r_hit_idx [MAX_PER_DIM:1];

    // response held between RESP cycles
    logic [7:0] r_base_q;
    logic [1:0] r_id_q, r_err_q;

    logic          w_accept, w_clear, w_req_bad, w_match_cur;
    logic [1:0]    w_err, w_rid, w_wr_id;
    logic [7:0]    w_base;
    logic          w_we, w_evict, w_lk_hit;
    logic [IW-1:0] w_wr_idx;
    logic [3:0]    w_occ;

    function automatic logic [7:0] slot_base(input logic [IW-1:0] idx);
        return 8'(idx) * 8'(SLOT_WORDS);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && req_valid && !clear;
    assign w_clear   = (r_state == S_IDLE) && clear;
    assign w_req_bad = (req_m == 3'd0) || (req_m > 3'd5) ||
                       (req_n == 3'd0) || (req_n > 3'd5) ||
                       (req_op && ((req_id == 2'd0) || (32'(req_id) > 32'(MAX_PER_DIM))));
    assign w_match_cur = r_valid[r_idx] && (r_sm[r_idx] == r_m) && (r_sn[r_idx] == r_n);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state: bad requests bypass the scan
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_req_bad ? S_RESP : S_SCAN;
            S_SCAN: if (r_idx == IW'(NUM_SLOTS - 1)) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // capture the request on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= 1'b0;
            r_m   <= '0;
            r_n   <= '0;
            r_id  <= '0;
            r_bad <= 1'b0;
        end else if (w_accept) begin
            r_op  <= req_op;
            r_m   <= req_m;
            r_n   <= req_n;
            r_id  <= req_id;
            r_bad <= w_req_bad;
        end
    end

    // scan one slot per cycle, accumulating count, free slot and id hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
            r_hit_found  <= '0;
            for (int k = 1; k <= MAX_PER_DIM; k++) r_hit_idx[k] <= '0;
        end else if (w_accept) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_free_found <= 1'b0;
            r_hit_found  <= '0;
        end else if (r_state == S_SCAN) begin
            r_idx <= r_idx + 1'b1;
            if (w_match_cur) r_cnt <= r_cnt + 1'b1;
            if (!r_valid[r_idx] && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
            for (int k = 1; k <= MAX_PER_DIM; k++) begin
                if (w_match_cur && (r_sid[r_idx] == 2'(k))) begin
                    r_hit_found[k] <= 1'b1;
                    r_hit_idx[k]   <= r_idx;
                end
            end
        end
    end

    // response decision and table-write plan, meaningful in RESP
    always_comb begin
        w_err    = ERR_OK;
        w_base   = 8'd0;
        w_rid    = 2'd0;
        w_we     = 1'b0;
        w_evict  = 1'b0;
        w_wr_idx = '0;
        w_wr_id  = 2'd0;
        w_lk_hit = 1'b0;
        if (r_bad) begin
            w_err = ERR_PARAM;
        end else if (!r_op) begin
            if (r_cnt < CW'(MAX_PER_DIM)) begin
                if (r_free_found) begin
                    w_we     = 1'b1;
                    w_wr_idx = r_free_idx;
                    w_wr_id  = 2'(r_cnt + 1'b1);
                    w_base   = slot_base(r_free_idx);
                    w_rid    = w_wr_id;
                end else begin
                    w_err = ERR_FULL;
                end
            end else begin
                // pair is full: oldest (id 1) is recycled as the newest
                w_we     = 1'b1;
                w_evict  = 1'b1;
                w_wr_idx = r_hit_idx[1];
                w_wr_id  = 2'(MAX_PER_DIM);
                w_base   = slot_base(r_hit_idx[1]);
                w_rid    = w_wr_id;
            end
        end else begin
            for (int k = 1; k <= MAX_PER_DIM; k++) begin
                if ((r_id == 2'(k)) && r_hit_found[k]) begin
                    w_lk_hit = 1'b1;
                    w_base   = slot_base(r_hit_idx[k]);
                    w_rid    = r_id;
                end
            end
            if (!w_lk_hit) w_err = ERR_NONE;
        end
    end

    // table update: clear in IDLE, allocation/eviction on the RESP edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_sm[i]  <= '0;
                r_sn[i]  <= '0;
                r_sid[i] <= '0;
            end
        end else if (w_clear) begin
            r_valid <= '0;
        end else if ((r_state == S_RESP) && w_we) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (IW'(i) == w_wr_idx) begin
                    r_valid[i] <= 1'b1;
                    r_sm[i]    <= r_m;
                    r_sn[i]    <= r_n;
                    r_sid[i]   <= w_wr_id;
                end else if (w_evict && r_valid[i] && (r_sm[i] == r_m) && (r_sn[i] == r_n)) begin
                    r_sid[i] <= r_sid[i] - 2'd1;
                end
            end
        end
    end

    // hold the last response after the RESP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base_q <= '0;
            r_id_q   <= '0;
            r_err_q  <= '0;
        end else if (r_state == S_RESP) begin
            r_base_q <= w_base;
            r_id_q   <= w_rid;
            r_err_q  <= w_err;
        end
    end

    // occupancy is the population count of valid slots
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_SLOTS; i++) w_occ = w_occ + 4'(r_valid[i]);
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_base  = resp_valid ? w_base : r_base_q;
    assign resp_id    = resp_valid ? w_rid  : r_id_q;
    assign resp_err   = resp_valid ? w_err  : r_err_q;
    assign occupancy  = w_occ;

endmodule
